fac_bus_master: RTL and testbench
=================================

// Module: fac_bus_master
// PURPOSE
//  Bus-master sequencer feeding the top-level bus (M_req/M_wr/M_address/M_dout ->
//  M_grant/M_din). It runs one factorial job per start pulse: program operand,
//  enable interrupt and start the core, release the bus, wait for f_interrupt,
//  then read the 64-bit result and clear the core. Sits directly upstream of top.
// PARAMETERS
//  A_OPERAND   8'h20  factorial core operand register
//  A_OPSTART   8'h21  write 1 = start
//  A_INTREN    8'h23  write 1 = interrupt enable
//  A_OPCLEAR   8'h24  write 1 = clear core / deassert interrupt
//  A_RESULT_H  8'h25  result[63:32]
//  A_RESULT_L  8'h26  result[31:0]
//  TIMEOUT     4096   max clk cycles waiting for f_interrupt (counter 16 bits)
// PORTS
//  clk          in   1   clock, all logic on rising edge
//  reset        in   1   synchronous, active-high reset
//  start        in   1   1-cycle job request; sampled only in IDLE
//  operand      in   32  factorial operand, captured when start accepted
//  busy         out  1   high from accepted start until done/err pulse
//  done         out  1   1-cycle pulse, result valid
//  err_timeout  out  1   1-cycle pulse, no f_interrupt within TIMEOUT
//  result       out  64  {RESULT_H,RESULT_L}; held until next accepted start
//  M_req        out  1   bus request
//  M_wr         out  1   1 = write, 0 = read
//  M_address    out  8   bus address
//  M_dout       out  32  write data
//  M_grant      in   1   bus grant from arbiter
//  M_din        in   32  read data
//  f_interrupt  in   1   factorial core done interrupt (level)
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, timeout counter 0; reset mid-job aborts it
//   (M_req drops on the next edge, no clear write is issued).
//  States: IDLE -> REQ1 -> W_OPR -> W_IEN -> W_START -> REL -> WAIT_INT ->
//   REQ2 -> R_H -> R_L -> W_CLR -> FIN -> IDLE.
//  IDLE: start=1 latches operand, busy=1, go REQ1. start while busy: ignored.
//  REQx: M_req=1, M_wr=0, M_address=0; advance on the first edge with M_grant=1.
//  Every access state lasts exactly 2 cycles with M_grant=1: address/M_wr/M_dout
//   stable both cycles; writes carry M_wr=1 for both; reads sample M_din on the
//   2nd edge. Data: W_OPR=operand, W_IEN=1, W_START=1, W_CLR=1.
//  If M_grant falls during an access, the access holds and its 2-cycle count
//   restarts when M_grant returns; no state is skipped.
//  REL: M_req=0, M_wr=0 for 1 cycle, then WAIT_INT.
//  WAIT_INT: bus idle (M_req=0); counter increments per cycle; f_interrupt=1 -> REQ2;
//   counter reaching TIMEOUT with no interrupt -> err_timeout pulse, busy=0, IDLE,
//   result unchanged. f_interrupt already high on entry is accepted at once.
//  R_H -> result[63:32], R_L -> result[31:0]. W_CLR drops f_interrupt in core.
//  FIN: M_req=0, M_wr=0, done=1 for 1 cycle, busy=0, back to IDLE; a start in
//   the FIN cycle is ignored (accepted from the following IDLE cycle).
//  M_req stays high continuously from REQ grant through the last access of a phase.
//  done and err_timeout never assert in the same cycle.
// TESTING
//  1 operand=4, grant tied 1 -> writes 20<=4, 23<=1, 21<=1, then 25, 26 reads,
//    24<=1; result=64'h18, done pulse 1 cycle, busy low after.
//  2 operand=0 -> result=64'h1; operand=20 -> result=64'h21C3_677C_82B4_0000.
//  3 grant delayed 7 cycles in REQ1 and dropped 3 cycles mid W_START -> same write
//    sequence, each access 2 granted cycles, no skipped/duplicated writes.
//  4 f_interrupt never rises, TIMEOUT=16 -> err_timeout at WAIT_INT cycle 16,
//    done stays 0, prior result unchanged, next start runs normally.
//  5 reset asserted in WAIT_INT and in R_L -> next cycle all outputs 0, IDLE;
//    start pulsed while busy -> ignored, operand not re-latched.

Source files
------------

// File: rtl/fac_bus_master.sv
// Bus-master sequencer: one factorial job per start pulse (program operand, enable
// interrupt, start core, release bus, wait for interrupt, read 64-bit result, clear core).
module fac_bus_master #(
  parameter logic [7:0]  A_OPERAND  = 8'h20,
  parameter logic [7:0]  A_OPSTART  = 8'h21,
  parameter logic [7:0]  A_INTREN   = 8'h23,
  parameter logic [7:0]  A_OPCLEAR  = 8'h24,
  parameter logic [7:0]  A_RESULT_H = 8'h25,
  parameter logic [7:0]  A_RESULT_L = 8'h26,
  parameter int unsigned TIMEOUT    = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] operand,
  output logic        busy,
  output logic        done,
  output logic        err_timeout,
  output logic [63:0] result,
  output logic        M_req,
  output logic        M_wr,
  output logic [7:0]  M_address,
  output logic [31:0] M_dout,
  input  logic        M_grant,
  input  logic [31:0] M_din,
  input  logic        f_interrupt
);

  typedef enum logic [3:0] {
    IDLE, REQ1, W_OPR, W_IEN, W_START, REL, WAIT_INT,
    REQ2, R_H, R_L, W_CLR, FIN
  } state_t;

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [31:0] operand_q;
  logic [63:0] result_q;
  logic [15:0] wait_cnt;
  logic        beat;
  logic        access;
  logic        last_beat;

  // An access needs two granted cycles in a row; a grant gap restarts the pair.
  assign access    = (state == W_OPR) || (state == W_IEN) || (state == W_START) ||
                     (state == R_H)   || (state == R_L)   || (state == W_CLR);
  assign last_beat = access & M_grant & beat;
  assign result    = result_q;

  always_comb begin
    state_nxt   = state;
    M_req       = 1'b0;
    M_wr        = 1'b0;
    M_address   = 8'h00;
    M_dout      = 32'h0;
    busy        = 1'b1;
    done        = 1'b0;
    err_timeout = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = REQ1;
      end
      REQ1: begin
        M_req = 1'b1;
        if (M_grant) state_nxt = W_OPR;
      end
      W_OPR: begin
        M_req     = 1'b1;
        M_wr      = 1'b1;
        M_address = A_OPERAND;
        M_dout    = operand_q;
        if (last_beat) state_nxt = W_IEN;
      end
      W_IEN: begin
        M_req     = 1'b1;
        M_wr      = 1'b1;
        M_address = A_INTREN;
        M_dout    = 32'd1;
        if (last_beat) state_nxt = W_START;
      end
      W_START: begin
        M_req     = 1'b1;
        M_wr      = 1'b1;
        M_address = A_OPSTART;
        M_dout    = 32'd1;
        if (last_beat) state_nxt = REL;
      end
      REL: state_nxt = WAIT_INT;
      WAIT_INT: begin
        // The error cycle is the last waiting cycle, so busy already reads low there.
        if (f_interrupt) begin
          state_nxt = REQ2;
        end else if (wait_cnt == TIMEOUT_LAST) begin
          err_timeout = 1'b1;
          busy        = 1'b0;
          state_nxt   = IDLE;
        end
      end
      REQ2: begin
        M_req = 1'b1;
        if (M_grant) state_nxt = R_H;
      end
      R_H: begin
        M_req     = 1'b1;
        M_address = A_RESULT_H;
        if (last_beat) state_nxt = R_L;
      end
      R_L: begin
        M_req     = 1'b1;
        M_address = A_RESULT_L;
        if (last_beat) state_nxt = W_CLR;
      end
      W_CLR: begin
        M_req     = 1'b1;
        M_wr      = 1'b1;
        M_address = A_OPCLEAR;
        M_dout    = 32'd1;
        if (last_beat) state_nxt = FIN;
      end
      FIN: begin
        busy      = 1'b0;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      operand_q <= 32'h0;
      result_q  <= 64'h0;
      wait_cnt  <= 16'h0;
      beat      <= 1'b0;
    end else begin
      state <= state_nxt;
      beat  <= access & M_grant & ~beat;
      if ((state == IDLE) && start) operand_q <= operand;
      if ((state == R_H) && last_beat) result_q[63:32] <= M_din;
      if ((state == R_L) && last_beat) result_q[31:0] <= M_din;
      if ((state == WAIT_INT) && (state_nxt == WAIT_INT)) wait_cnt <= wait_cnt + 16'd1;
      else wait_cnt <= 16'h0;
    end
  end

endmodule

// File: tb/tb_fac_bus_master.sv
// Bench for fac_bus_master: a bus monitor plus a behavioural factorial-core slave
// model drive randomized jobs and check the transaction log and results.
module tb_fac_bus_master;

  localparam int         TIMEOUT    = 16;
  localparam logic [7:0] A_OPERAND  = 8'h20;
  localparam logic [7:0] A_OPSTART  = 8'h21;
  localparam logic [7:0] A_INTREN   = 8'h23;
  localparam logic [7:0] A_OPCLEAR  = 8'h24;
  localparam logic [7:0] A_RESULT_H = 8'h25;
  localparam logic [7:0] A_RESULT_L = 8'h26;

  typedef struct {
    logic [7:0]  addr;
    logic        wr;
    logic [31:0] data;
  } txn_t;

  logic        clk = 1'b0;
  logic        reset, start, M_grant, f_interrupt;
  logic [31:0] operand, M_din, M_dout;
  logic        busy, done, err_timeout, M_req, M_wr;
  logic [63:0] result;
  logic [7:0]  M_address;

  int checks = 0;
  int errors = 0;

  txn_t        log_q[$];
  int          cyc = 0, run = 0;
  logic [7:0]  run_addr;
  logic        run_wr;
  int          start_wr_cyc, done_cyc, err_cyc, done_cnt, err_cnt, req_after_start;
  bit          start_logged, both_seen, busy_at_done, busy_at_err, fin_poke;
  logic [31:0] core_operand;
  logic [63:0] core_fact;
  bit          core_ien, int_enable;
  int          int_delay;
  int          grant_mode, req_wait, drop_left;
  bit          dropped;

  always #5 clk = ~clk;

  fac_bus_master #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .start(start), .operand(operand),
    .busy(busy), .done(done), .err_timeout(err_timeout), .result(result),
    .M_req(M_req), .M_wr(M_wr), .M_address(M_address), .M_dout(M_dout),
    .M_grant(M_grant), .M_din(M_din), .f_interrupt(f_interrupt)
  );

  assign M_din = (M_address == A_RESULT_H) ? core_fact[63:32] :
                 (M_address == A_RESULT_L) ? core_fact[31:0]  : 32'hA5A5_5A5A;

  function automatic logic [63:0] fact(input logic [31:0] n);
    logic [63:0] r = 64'd1;
    for (int i = 2; i <= int'(n); i++) r = r * 64'(i);
    return r;
  endfunction

  function automatic logic [63:0] pack(input txn_t t);
    return {23'b0, t.addr, t.wr, t.data};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic set_grant();
    case (grant_mode)
      0: M_grant = 1'b1;
      1: M_grant = ($urandom_range(0, 3) != 0);
      default: begin
        if (drop_left > 0) begin
          M_grant = 1'b0;
          drop_left--;
        end else if (M_req && (M_address == 8'h00) && (req_wait < 7)) begin
          M_grant = 1'b0;
          req_wait++;
        end else if ((M_address == A_OPSTART) && (run == 1) && !dropped) begin
          dropped   = 1'b1;
          M_grant   = 1'b0;
          drop_left = 2;
        end else begin
          M_grant = 1'b1;
        end
      end
    endcase
  endtask

  // One bus cycle: observe at the falling edge, then advance the core model after the rising edge.
  task automatic run_cycle();
    @(negedge clk);
    cyc++;
    if (!reset) begin
      if (start_logged && M_req) req_after_start++;
      if (M_req && M_grant && (M_address != 8'h00)) begin
        if ((run == 0) || (M_address != run_addr) || (M_wr != run_wr)) run = 1;
        else run++;
        run_addr = M_address;
        run_wr   = M_wr;
        if (run == 2) begin
          log_q.push_back('{addr: M_address, wr: M_wr, data: (M_wr ? M_dout : M_din)});
          run = 0;
          if (M_wr && (M_address == A_OPERAND)) core_operand = M_dout;
          if (M_wr && (M_address == A_INTREN) && (M_dout == 32'd1)) core_ien = 1'b1;
          if (M_wr && (M_address == A_OPSTART) && (M_dout == 32'd1)) begin
            core_fact    = fact(core_operand);
            int_delay    = $urandom_range(0, 6);
            start_wr_cyc = cyc;
            start_logged = 1'b1;
          end
          if (M_wr && (M_address == A_OPCLEAR) && (M_dout == 32'd1)) f_interrupt = 1'b0;
        end
      end else begin
        run = 0;
      end
      if (done) begin
        done_cnt++;
        done_cyc     = cyc;
        busy_at_done = busy;
        if (fin_poke) start = 1'b1;
      end
      if (err_timeout) begin
        err_cnt++;
        err_cyc     = cyc;
        busy_at_err = busy;
      end
      if (done && err_timeout) both_seen = 1'b1;
    end
    @(posedge clk);
    #1;
    if (int_delay > 0) begin
      int_delay--;
    end else if (int_delay == 0) begin
      if (int_enable && core_ien) f_interrupt = 1'b1;
      int_delay = -1;
    end
    set_grant();
  endtask

  task automatic clear_job_state(input int gmode);
    log_q.delete();
    done_cnt = 0; err_cnt = 0; req_after_start = 0; run = 0;
    start_logged = 1'b0; both_seen = 1'b0; req_wait = 0; drop_left = 0; dropped = 1'b0;
    grant_mode = gmode;
  endtask

  task automatic compare_log(input string tag, input logic [31:0] op, input int n);
    txn_t exp_q[$];
    logic [63:0] f;
    f = fact(op);
    exp_q.push_back('{addr: A_OPERAND,  wr: 1'b1, data: op});
    exp_q.push_back('{addr: A_INTREN,   wr: 1'b1, data: 32'd1});
    exp_q.push_back('{addr: A_OPSTART,  wr: 1'b1, data: 32'd1});
    exp_q.push_back('{addr: A_RESULT_H, wr: 1'b0, data: f[63:32]});
    exp_q.push_back('{addr: A_RESULT_L, wr: 1'b0, data: f[31:0]});
    exp_q.push_back('{addr: A_OPCLEAR,  wr: 1'b1, data: 32'd1});
    checkOutput({tag, " log size"}, 64'(log_q.size()), 64'(n));
    for (int i = 0; (i < n) && (i < log_q.size()); i++)
      checkOutput($sformatf("%s txn%0d", tag, i), pack(log_q[i]), pack(exp_q[i]));
  endtask

  task automatic applyStimulus(input string tag, input logic [31:0] op, input int gmode,
                               input bit expect_timeout, input bit poke_busy);
    logic [63:0] prev_result;
    int t;
    clear_job_state(gmode);
    int_enable  = !expect_timeout;
    fin_poke    = !expect_timeout;
    prev_result = result;
    set_grant();
    checkOutput({tag, " idle busy"}, 64'(busy), 64'd0);
    start   = 1'b1;
    operand = op;
    run_cycle();
    operand = $urandom;
    t = 0;
    while ((done_cnt == 0) && (err_cnt == 0) && (t < 400)) begin
      start = (poke_busy && (t == 0));
      if (start) operand = op + 32'd9;
      run_cycle();
      t++;
    end
    checkOutput({tag, " finished"}, 64'(done_cnt + err_cnt), 64'd1);
    checkOutput({tag, " done+err overlap"}, 64'(both_seen), 64'd0);
    if (expect_timeout) begin
      checkOutput({tag, " err count"}, 64'(err_cnt), 64'd1);
      checkOutput({tag, " done count"}, 64'(done_cnt), 64'd0);
      checkOutput({tag, " err cycle"}, 64'(err_cyc - start_wr_cyc), 64'(TIMEOUT + 1));
      checkOutput({tag, " busy at err"}, 64'(busy_at_err), 64'd0);
      checkOutput({tag, " bus idle in wait"}, 64'(req_after_start), 64'd0);
      checkOutput({tag, " result held"}, result, prev_result);
      compare_log(tag, op, 3);
    end else begin
      checkOutput({tag, " err count"}, 64'(err_cnt), 64'd0);
      checkOutput({tag, " busy at done"}, 64'(busy_at_done), 64'd0);
      checkOutput({tag, " busy after fin"}, 64'(busy), 64'd0);
      checkOutput({tag, " done width"}, 64'(done), 64'd0);
      checkOutput({tag, " result"}, result, fact(op));
      compare_log(tag, op, 6);
    end
    start    = 1'b0;
    fin_poke = 1'b0;
    run_cycle();
  endtask

  task automatic reset_mid(input string tag, input logic [31:0] op, input bit in_read);
    int t;
    bit hit;
    int clr;
    clear_job_state(0);
    int_enable = in_read;
    set_grant();
    start   = 1'b1;
    operand = op;
    run_cycle();
    start = 1'b0;
    t = 0;
    hit = 1'b0;
    while (!hit && (t < 200)) begin
      if (in_read) hit = M_req && (M_address == A_RESULT_L);
      else         hit = start_logged && ((cyc - start_wr_cyc) >= 4);
      if (!hit) begin
        run_cycle();
        t++;
      end
    end
    checkOutput({tag, " reached"}, 64'(hit), 64'd1);
    checkOutput({tag, " busy before"}, 64'(busy), 64'd1);
    reset = 1'b1;
    run_cycle();
    checkOutput({tag, " M_req"}, 64'(M_req), 64'd0);
    checkOutput({tag, " M_wr"}, 64'(M_wr), 64'd0);
    checkOutput({tag, " M_address"}, 64'(M_address), 64'd0);
    checkOutput({tag, " M_dout"}, 64'(M_dout), 64'd0);
    checkOutput({tag, " busy"}, 64'(busy), 64'd0);
    checkOutput({tag, " done"}, 64'(done), 64'd0);
    checkOutput({tag, " err"}, 64'(err_timeout), 64'd0);
    checkOutput({tag, " result"}, result, 64'd0);
    clr = 0;
    foreach (log_q[i]) if (log_q[i].addr == A_OPCLEAR) clr++;
    checkOutput({tag, " no clear write"}, 64'(clr), 64'd0);
    reset       = 1'b0;
    f_interrupt = 1'b0;
    int_delay   = -1;
    core_ien    = 1'b0;
    run         = 0;
    run_cycle();
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; operand = 32'h0; M_grant = 1'b0; f_interrupt = 1'b0;
    core_operand = 32'h0; core_fact = 64'h0; core_ien = 1'b0; int_enable = 1'b1;
    int_delay = -1; grant_mode = 0; fin_poke = 1'b0;
    clear_job_state(0);
    repeat (3) run_cycle();
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset M_req", 64'(M_req), 64'd0);
    checkOutput("reset done", 64'(done), 64'd0);
    checkOutput("reset err", 64'(err_timeout), 64'd0);
    checkOutput("reset result", result, 64'd0);
    reset = 1'b0;
    run_cycle();

    $display("[TB] directed jobs");
    applyStimulus("op4", 32'd4, 0, 1'b0, 1'b0);
    checkOutput("op4 const", result, 64'h18);
    applyStimulus("op0", 32'd0, 0, 1'b0, 1'b0);
    checkOutput("op0 const", result, 64'h1);
    applyStimulus("op20", 32'd20, 0, 1'b0, 1'b0);
    checkOutput("op20 const", result, 64'h21C3_677C_82B4_0000);
    applyStimulus("grant stall", 32'd5, 2, 1'b0, 1'b0);
    applyStimulus("timeout", 32'd3, 0, 1'b1, 1'b0);
    checkOutput("timeout keeps 5!", result, 64'd120);
    applyStimulus("after timeout", 32'd6, 0, 1'b0, 1'b0);
    reset_mid("rst wait", 32'd7, 1'b0);
    reset_mid("rst read", 32'd8, 1'b1);
    applyStimulus("start while busy", 32'd7, 0, 1'b0, 1'b1);

    $display("[TB] randomized jobs");
    for (int k = 0; k < 8; k++)
      applyStimulus($sformatf("rand%0d", k), 32'($urandom_range(0, 25)),
                    int'($urandom_range(0, 1)), 1'b0, ($urandom_range(0, 3) == 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
